// File: rtl/rx_sample_packer_pkg.sv
// Shared types and constants for the RX sample packer: write-FSM states, control-register
// bit positions and the default control address.
package rx_sample_packer_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StWrQ  = 1'b1
    } pack_state_e;

    localparam int unsigned CtrlClrOvr = 0;
    localparam int unsigned CtrlFlush  = 1;

    localparam logic [6:0] DefaultCtrlAddr = 7'd40;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/rx_fifo_sync.sv
// Single-clock FIFO with registered read port (latency 1), word level count and synchronous
// flush. Async active-low reset clears pointers, level and read outputs.
module rx_fifo_sync #(
    parameter int unsigned DEPTH_LOG2 = 9,
    parameter int unsigned WIDTH      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int unsigned         DepthWords = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LevelFull  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] LevelOne   = 1;
    localparam logic [DEPTH_LOG2-1:0] PtrOne   = 1;

    logic [WIDTH-1:0]      mem_q [DepthWords];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [WIDTH-1:0]      rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  full;
    logic                  push;
    logic                  pop;

    always_comb begin
        full = (level_q == LevelFull);
        // Flush wins over any same-cycle push or pop.
        push = wr_en & ~full & ~flush;
        pop  = rd_en & (level_q != '0) & ~flush;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = pop;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + PtrOne;
                rd_data_d = mem_q[rd_ptr_q];
            end
            if (push && !pop) begin
                level_d = level_q + LevelOne;
            end else if (pop && !push) begin
                level_d = level_q - LevelOne;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign empty    = (level_q == '0);
    assign level    = level_q;

endmodule

// File: rtl/rx_sample_packer.sv
// Packs I/Q sample pairs atomically into a word FIFO (I then Q), with sticky overrun flag and
// control-register clear/flush. Define RX_OVERRUN_COUNT_EN to add the saturating drop counter.
module rx_sample_packer
    import rx_sample_packer_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 9,
    parameter logic [6:0]  CTRL_ADDR  = DefaultCtrlAddr
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  strobe_in,
    input  logic [15:0]           i_in,
    input  logic [15:0]           q_in,
    input  logic [6:0]            serial_addr,
    input  logic [31:0]           serial_data,
    input  logic                  serial_strobe,
    input  logic                  rd_en,
    output logic [15:0]           rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overrun,
    output logic [15:0]           overrun_count
);

    localparam logic [DEPTH_LOG2:0] LevelFull = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] PairWords = 2;

    pack_state_e         state_q, state_d;
    logic [15:0]         q_hold_q, q_hold_d;
    logic                overrun_q, overrun_d;
    logic                ctrl_wr;
    logic                clr_ovr;
    logic                flush;
    logic                new_pair;
    logic                pair_room;
    logic                drop;
    logic                fifo_wr_en;
    logic [15:0]         fifo_wr_data;
    logic [DEPTH_LOG2:0] fifo_level;
    logic [DEPTH_LOG2:0] free_words;
    logic                unused_serial_data;

    assign unused_serial_data = ^serial_data[31:2];

    always_comb begin
        ctrl_wr    = serial_strobe && (serial_addr == CTRL_ADDR);
        clr_ovr    = ctrl_wr && serial_data[CtrlClrOvr];
        flush      = ctrl_wr && serial_data[CtrlFlush];
        new_pair   = strobe_in && enable;
        free_words = LevelFull - fifo_level;
        // Room is judged for both words up front so the Q write can never hit a full FIFO.
        pair_room  = (free_words >= PairWords);

        state_d      = state_q;
        q_hold_d     = q_hold_q;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = i_in;
        drop         = 1'b0;

        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (new_pair) begin
                        if (pair_room) begin
                            fifo_wr_en = 1'b1;
                            q_hold_d   = q_in;
                            state_d    = StWrQ;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                end
                StWrQ: begin
                    fifo_wr_en   = 1'b1;
                    fifo_wr_data = q_hold_q;
                    state_d      = StIdle;
                    drop         = new_pair;
                end
                default: state_d = StIdle;
            endcase
        end

        if (clr_ovr) begin
            overrun_d = 1'b0;
        end else if (drop) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            q_hold_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_hold_q  <= q_hold_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef RX_OVERRUN_COUNT_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        if (clr_ovr) begin
            count_d = '0;
        end else if (drop) begin
            count_d = sat_inc16(count_q);
        end else begin
            count_d = count_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign overrun_count = count_q;
`else
    assign overrun_count = 16'd0;
`endif

    rx_fifo_sync #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (16)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .wr_en    (fifo_wr_en),
        .wr_data  (fifo_wr_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .level    (fifo_level)
    );

    assign level   = fifo_level;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_rx_sample_packer.sv
// Self-checking bench for rx_sample_packer with an 8-word FIFO; directed vectors plus
// hand-written sequences for drops, flush, counter saturation and reset mid-pair.
module tb_rx_sample_packer;

    localparam int unsigned DL = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          strobe_in;
    logic [15:0]   i_in;
    logic [15:0]   q_in;
    logic [6:0]    serial_addr;
    logic [31:0]   serial_data;
    logic          serial_strobe;
    logic          rd_en;
    logic [15:0]   rd_data;
    logic          rd_valid;
    logic          empty;
    logic [DL:0]   level;
    logic          overrun;
    logic [15:0]   overrun_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
        logic [DL:0] exp_level;
        logic        exp_ovr;
    } vec_t;

    vec_t tbl [5];

`ifdef RX_OVERRUN_COUNT_EN
    localparam bit CountEn = 1'b1;
`else
    localparam bit CountEn = 1'b0;
`endif

    rx_sample_packer #(
        .DEPTH_LOG2 (DL),
        .CTRL_ADDR  (7'd40)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .strobe_in     (strobe_in),
        .i_in          (i_in),
        .q_in          (q_in),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .serial_strobe (serial_strobe),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .empty         (empty),
        .level         (level),
        .overrun       (overrun),
        .overrun_count (overrun_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_pair(input logic [15:0] i, input logic [15:0] q);
        strobe_in = 1'b1;
        i_in      = i;
        q_in      = q;
        @(negedge clock);
        strobe_in = 1'b0;
        @(negedge clock);
    endtask

    task automatic read_word(input string name, input logic [15:0] exp);
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
        chk({name, "_valid"}, {31'd0, rd_valid}, 32'd1);
        chk({name, "_data"}, {16'd0, rd_data}, {16'd0, exp});
    endtask

    task automatic ctrl_write(input logic [31:0] data);
        serial_strobe = 1'b1;
        serial_addr   = 7'd40;
        serial_data   = data;
        @(negedge clock);
        serial_strobe = 1'b0;
        serial_data   = '0;
    endtask

    initial begin
        tbl[0] = '{i: 16'h1234, q: 16'hABCD, exp_level: 4'd2, exp_ovr: 1'b0};
        tbl[1] = '{i: 16'h8000, q: 16'h7FFF, exp_level: 4'd4, exp_ovr: 1'b0};
        tbl[2] = '{i: 16'h0001, q: 16'hFFFE, exp_level: 4'd6, exp_ovr: 1'b0};
        tbl[3] = '{i: 16'h5A5A, q: 16'hA5A5, exp_level: 4'd8, exp_ovr: 1'b0};
        tbl[4] = '{i: 16'hDEAD, q: 16'hBEEF, exp_level: 4'd8, exp_ovr: 1'b1};

        reset = 1'b0; enable = 1'b1; strobe_in = 1'b0; i_in = '0; q_in = '0;
        serial_addr = '0; serial_data = '0; serial_strobe = 1'b0; rd_en = 1'b0;

        // Reset and idle reads
        repeat (3) @(negedge clock);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_level", {28'd0, level}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_count", {16'd0, overrun_count}, 32'd0);
        chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        rd_en = 1'b1;
        @(negedge clock);
        @(negedge clock);
        rd_en = 1'b0;
        chk("idle_rd_valid", {31'd0, rd_valid}, 32'd0);

        // Two pairs, strobes four cycles apart
        send_pair(16'h1234, 16'hABCD);
        repeat (2) @(negedge clock);
        send_pair(16'h8000, 16'h7FFF);
        chk("t2_level4", {28'd0, level}, 32'd4);
        read_word("t2_w0", 16'h1234);
        read_word("t2_w1", 16'hABCD);
        read_word("t2_w2", 16'h8000);
        read_word("t2_w3", 16'h7FFF);
        @(negedge clock);
        chk("t2_valid_drop", {31'd0, rd_valid}, 32'd0);
        chk("t2_level0", {28'd0, level}, 32'd0);

        // Fill to full from the table; fifth pair must be dropped
        for (int k = 0; k < 5; k++) begin
            send_pair(tbl[k].i, tbl[k].q);
            chk($sformatf("t3_level_%0d", k), {28'd0, level}, {28'd0, tbl[k].exp_level});
            chk($sformatf("t3_ovr_%0d", k), {31'd0, overrun}, {31'd0, tbl[k].exp_ovr});
        end
        chk("t3_count", {16'd0, overrun_count}, CountEn ? 32'd1 : 32'd0);
        for (int k = 0; k < 4; k++) begin
            read_word($sformatf("t3_i%0d", k), tbl[k].i);
            read_word($sformatf("t3_q%0d", k), tbl[k].q);
        end
        @(negedge clock);
        chk("t3_empty", {31'd0, empty}, 32'd1);
        ctrl_write(32'h1);
        chk("clr_overrun", {31'd0, overrun}, 32'd0);
        chk("clr_count", {16'd0, overrun_count}, 32'd0);

        // Strobe with enable low is ignored
        enable = 1'b0;
        send_pair(16'h1111, 16'h2222);
        enable = 1'b1;
        chk("dis_level", {28'd0, level}, 32'd0);
        chk("dis_overrun", {31'd0, overrun}, 32'd0);

        // Back-to-back strobes: second pair dropped
        strobe_in = 1'b1; i_in = 16'hC001; q_in = 16'hC002;
        @(negedge clock);
        i_in = 16'hD001; q_in = 16'hD002;
        @(negedge clock);
        strobe_in = 1'b0;
        @(negedge clock);
        chk("t4_level", {28'd0, level}, 32'd2);
        chk("t4_overrun", {31'd0, overrun}, 32'd1);
        chk("t4_count", {16'd0, overrun_count}, CountEn ? 32'd1 : 32'd0);
        read_word("t4_i", 16'hC001);
        read_word("t4_q", 16'hC002);
        chk("t4_empty", {31'd0, empty}, 32'd1);
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
        chk("t4_empty_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("t4_empty_rd_hold", {16'd0, rd_data}, 32'h0000C002);

        // Clear + flush with six words stored
        send_pair(16'h0A01, 16'h0A02);
        send_pair(16'h0B01, 16'h0B02);
        send_pair(16'h0C01, 16'h0C02);
        chk("t5_level6", {28'd0, level}, 32'd6);
        ctrl_write(32'h3);
        chk("t5_level0", {28'd0, level}, 32'd0);
        chk("t5_empty", {31'd0, empty}, 32'd1);
        chk("t5_overrun", {31'd0, overrun}, 32'd0);
        chk("t5_count", {16'd0, overrun_count}, 32'd0);
        send_pair(16'h0101, 16'h0202);
        read_word("t5_i", 16'h0101);
        read_word("t5_q", 16'h0202);

        // Counter saturation against a full FIFO
        for (int k = 0; k < 4; k++) send_pair(tbl[k].i, tbl[k].q);
        strobe_in = 1'b1;
        repeat (70000) @(negedge clock);
        strobe_in = 1'b0;
        @(negedge clock);
        chk("t6_count_sat", {16'd0, overrun_count}, CountEn ? 32'h0000FFFF : 32'd0);
        chk("t6_overrun", {31'd0, overrun}, 32'd1);
        chk("t6_level", {28'd0, level}, 32'd8);
        read_word("t6_first", tbl[0].i);
        ctrl_write(32'h3);

        // Async reset while the Q word is pending
        strobe_in = 1'b1; i_in = 16'h7777; q_in = 16'h8888;
        @(negedge clock);
        strobe_in = 1'b0;
        chk("t6_midpair_level", {28'd0, level}, 32'd1);
        reset = 1'b0;
        #1;
        chk("t6_rst_level", {28'd0, level}, 32'd0);
        chk("t6_rst_empty", {31'd0, empty}, 32'd1);
        chk("t6_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("t6_rst_rd_data", {16'd0, rd_data}, 32'd0);
        chk("t6_rst_overrun", {31'd0, overrun}, 32'd0);
        chk("t6_rst_count", {16'd0, overrun_count}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("t6_no_orphan", {28'd0, level}, 32'd0);
        send_pair(16'h4321, 16'h8765);
        read_word("t6_post_i", 16'h4321);
        read_word("t6_post_q", 16'h8765);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
